// File: rtl/clock_ratio_detector.sv
// Measures period and high time of a divided clock in clk_i cycles, with lock.
// Optional duty-cycle qualification of lock: define CLOCK_RATIO_DUTY_CHECK_EN.
module clock_ratio_detector #(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4,
   parameter int TOL      = 0
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             div_clk_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             locked_o,
   output logic             meas_valid_o,
   output logic             err_o
);

   // LOCK_CNT=1 still needs one confirming period after the reference
   localparam int LOCK_M = (LOCK_CNT > 1) ? LOCK_CNT - 1 : 1;
   localparam int MC_W   = $clog2(LOCK_M + 1);

   localparam logic [CNT_W-1:0] PMAX  = '1;
   localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
   localparam logic [MC_W-1:0]  MC_LK = MC_W'(LOCK_M);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_ACQ,
      ST_LOCK
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic [CNT_W-1:0] r_pcnt;
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_high;
   logic [CNT_W-1:0] r_ref;
   logic [CNT_W-1:0] w_ref_nx;
   logic [MC_W-1:0]  r_mcnt;
   logic [MC_W-1:0]  w_mcnt_nx;
   logic [MC_W-1:0]  w_mcnt_inc;
   logic             r_locked;
   logic             w_locked_nx;
   logic             r_mv;
   logic             w_mv_nx;
   logic             r_err;
   logic             w_err_nx;

   logic             w_rise;
   logic             w_fall;
   logic             w_psat;
   logic             w_hsat;
   logic             w_tmo;
   logic [CNT_W-1:0] w_pdiff;
   logic             w_match;
   logic             w_ok;

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;
   assign w_psat = (r_pcnt == PMAX);
   assign w_hsat = (r_hcnt == PMAX);
   assign w_tmo  = w_psat & ~w_rise;

   assign w_pdiff = (r_pcnt >= r_ref) ? (r_pcnt - r_ref)
                                      : (r_ref - r_pcnt);
   assign w_match = (w_pdiff <= TOL_V);

`ifdef CLOCK_RATIO_DUTY_CHECK_EN
   localparam logic [CNT_W:0] DUTY_TOL = (CNT_W+1)'(2 + 2 * TOL);

   logic [CNT_W:0] w_h2;
   logic [CNT_W:0] w_p1;
   logic [CNT_W:0] w_ddiff;
   logic           w_duty_ok;

   assign w_h2      = {r_high, 1'b0};
   assign w_p1      = {1'b0, r_pcnt};
   assign w_ddiff   = (w_h2 >= w_p1) ? (w_h2 - w_p1) : (w_p1 - w_h2);
   assign w_duty_ok = (w_ddiff <= DUTY_TOL);
   assign w_ok      = w_match & w_duty_ok;
`else
   assign w_ok      = w_match;
`endif

   assign w_mcnt_inc = r_mcnt + 1'b1;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s3   <= 1'b0;
         r_pcnt <= '0;
         r_hcnt <= '0;
         r_high <= '0;
      end else begin
         r_s1 <= div_clk_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (w_rise) begin
            r_pcnt <= ONE;
         end else if (!w_psat) begin
            r_pcnt <= r_pcnt + 1'b1;
         end
         if (w_rise) begin
            r_hcnt <= '0;
         end else if (r_s2 && !w_hsat) begin
            r_hcnt <= r_hcnt + 1'b1;
         end
         // high time includes the cycle the rise was seen in
         if (w_fall) begin
            r_high <= w_hsat ? r_hcnt : r_hcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state  <= ST_IDLE;
         r_ref    <= '0;
         r_mcnt   <= '0;
         r_locked <= 1'b0;
         r_mv     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_ref    <= w_ref_nx;
         r_mcnt   <= w_mcnt_nx;
         r_locked <= w_locked_nx;
         r_mv     <= w_mv_nx;
         r_err    <= w_err_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_ref_nx    = r_ref;
      w_mcnt_nx   = r_mcnt;
      w_locked_nx = r_locked;
      w_mv_nx     = 1'b0;
      w_err_nx    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nx = ST_ARM;
            end
         end
         ST_ARM: begin
            if (w_rise) begin
               w_mv_nx    = 1'b1;
               w_ref_nx   = r_pcnt;
               w_mcnt_nx  = '0;
               w_state_nx = ST_ACQ;
            end else if (w_tmo) begin
               w_err_nx    = 1'b1;
               w_locked_nx = 1'b0;
               w_ref_nx    = '0;
               w_state_nx  = ST_IDLE;
            end
         end
         ST_ACQ: begin
            if (w_rise) begin
               w_mv_nx = 1'b1;
               if (w_ok) begin
                  w_mcnt_nx = w_mcnt_inc;
                  if (w_mcnt_inc == MC_LK) begin
                     w_locked_nx = 1'b1;
                     w_state_nx  = ST_LOCK;
                  end
               end else begin
                  w_ref_nx  = r_pcnt;
                  w_mcnt_nx = '0;
               end
            end else if (w_tmo) begin
               w_err_nx    = 1'b1;
               w_locked_nx = 1'b0;
               w_ref_nx    = '0;
               w_state_nx  = ST_IDLE;
            end
         end
         ST_LOCK: begin
            if (w_rise) begin
               w_mv_nx = 1'b1;
               if (!w_ok) begin
                  w_err_nx    = 1'b1;
                  w_locked_nx = 1'b0;
                  w_ref_nx    = r_pcnt;
                  w_mcnt_nx   = '0;
                  w_state_nx  = ST_ACQ;
               end
            end else if (w_tmo) begin
               w_err_nx    = 1'b1;
               w_locked_nx = 1'b0;
               w_ref_nx    = '0;
               w_state_nx  = ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   assign period_o     = r_ref;
   assign high_o       = r_high;
   assign locked_o     = r_locked;
   assign meas_valid_o = r_mv;
   assign err_o        = r_err;

endmodule
